microwave_timer_ctrl: RTL and testbench

MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

---
 rtl/microwave_timer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller.
// Keypad digits shift into a BCD M:SS display, start cooks and counts
// the display down once per second, and a DONE phase beeps for three
// ticks before returning to IDLE. Door opening or stop pauses cooking.
// Strobes (tick_1hz, key_valid, start, stop) are one-cycle pulses; there
// is no valid/ready handshake, so every input is acted on in the cycle it
// is seen or dropped.
module microwave_timer_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic [3:0] bmin,
    output logic [3:0] bsec_tens,
    output logic [3:0] bsec_ones,
    output logic       magnetron_on,
    output logic       done_beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     cur_state;
    logic [1:0] beep_ticks;

    logic       key_ok;
    logic       time_zero;
    logic       dec_zero;
    logic [3:0] dec_min;
    logic [3:0] dec_tens;
    logic [3:0] dec_ones;

    // State register doubles as the debug/state output.
    assign state = cur_state;

    // A key is usable only if it is a real digit and the shift cannot push
    // a value above 5 into the tens-of-seconds position.
    assign key_ok    = key_valid && (key_digit <= 4'd9) && (bsec_ones <= 4'd5);
    assign time_zero = (bmin == 4'd0) && (bsec_tens == 4'd0) && (bsec_ones == 4'd0);
    assign dec_zero  = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    // One-second BCD decrement of M:SS with borrow from ones to tens to minutes.
    always_comb begin
        dec_min  = bmin;
        dec_tens = bsec_tens;
        dec_ones = bsec_ones;
        if (bsec_ones != 4'd0) begin
            dec_ones = bsec_ones - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (bsec_tens != 4'd0) begin
                dec_tens = bsec_tens - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = bmin - 4'd1;
            end
        end
    end

    // Controller FSM with registered time digits, heater and beeper outputs.
    // Within a cycle: stop beats door-open beats start beats key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state    <= IDLE;
            bmin         <= 4'd0;
            bsec_tens    <= 4'd0;
            bsec_ones    <= 4'd0;
            magnetron_on <= 1'b0;
            done_beep    <= 1'b0;
            beep_ticks   <= 2'd0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (!stop && key_ok) begin
                        bmin      <= bsec_tens;
                        bsec_tens <= bsec_ones;
                        bsec_ones <= key_digit;
                        cur_state <= SET;
                    end
                end
                SET: begin
                    if (stop) begin
                        bmin      <= 4'd0;
                        bsec_tens <= 4'd0;
                        bsec_ones <= 4'd0;
                        cur_state <= IDLE;
                    end else if (start && door_closed && !time_zero) begin
                        cur_state    <= COOK;
                        magnetron_on <= 1'b1;
                    end else if (key_ok) begin
                        bmin      <= bsec_tens;
                        bsec_tens <= bsec_ones;
                        bsec_ones <= key_digit;
                    end
                end
                COOK: begin
                    if (stop || !door_closed) begin
                        // Time is frozen; a coincident tick is discarded.
                        cur_state    <= PAUSE;
                        magnetron_on <= 1'b0;
                    end else if (tick_1hz) begin
                        if (time_zero || dec_zero) begin
                            cur_state    <= DONE;
                            magnetron_on <= 1'b0;
                            done_beep    <= 1'b1;
                            beep_ticks   <= 2'd0;
                        end
                        if (!time_zero) begin
                            bmin      <= dec_min;
                            bsec_tens <= dec_tens;
                            bsec_ones <= dec_ones;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        bmin      <= 4'd0;
                        bsec_tens <= 4'd0;
                        bsec_ones <= 4'd0;
                        cur_state <= IDLE;
                    end else if (start && door_closed) begin
                        cur_state    <= COOK;
                        magnetron_on <= 1'b1;
                    end
                end
                DONE: begin
                    // Any button press silences the beeper; the key is discarded.
                    if (stop || start || key_valid) begin
                        cur_state  <= IDLE;
                        done_beep  <= 1'b0;
                        beep_ticks <= 2'd0;
                    end else if (tick_1hz) begin
                        if (beep_ticks == 2'd2) begin
                            cur_state  <= IDLE;
                            done_beep  <= 1'b0;
                            beep_ticks <= 2'd0;
                        end else begin
                            beep_ticks <= beep_ticks + 2'd1;
                        end
                    end
                end
                default: begin
                    cur_state    <= IDLE;
                    magnetron_on <= 1'b0;
                    done_beep    <= 1'b0;
                    beep_ticks   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Testbench for microwave_timer_ctrl: directed scenarios with constant
// expectations plus a randomized run checked every cycle against a
// seconds-based reference model.
module tb_microwave_timer_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] bmin, bsec_tens, bsec_ones;
    logic       magnetron_on, done_beep;
    logic [2:0] state;

    always #5 clk = ~clk;

    microwave_timer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop         (stop),
        .door_closed  (door_closed),
        .bmin         (bmin),
        .bsec_tens    (bsec_tens),
        .bsec_ones    (bsec_ones),
        .magnetron_on (magnetron_on),
        .done_beep    (done_beep),
        .state        (state)
    );

    localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] obs;
    logic [16:0] exp_v;
    assign obs = {state, bmin, bsec_tens, bsec_ones, magnetron_on, done_beep};

    // Expected-output constructor: state, M, S-tens, S-ones, heater, beeper.
    function automatic logic [16:0] pack(input int st, input int m, input int t,
                                         input int o, input int mag, input int bp);
        return {st[2:0], m[3:0], t[3:0], o[3:0], mag[0], bp[0]};
    endfunction

    // ---------------- reference model ----------------
    // Time is held as a plain number of seconds; digits are derived from it.
    int m_state = S_IDLE;
    int m_secs  = 0;
    int m_beeps = 0;

    function automatic int shift_in(input int secs, input int d);
        return ((secs % 60) / 10) * 60 + (secs % 10) * 10 + d;
    endfunction

    function automatic void model_step(input bit rn, input bit t, input bit kv,
                                       input int kd, input bit st, input bit sp,
                                       input bit dc);
        bit key_ok;
        key_ok = kv && (kd <= 9) && ((m_secs % 10) <= 5);
        if (!rn) begin
            m_state = S_IDLE; m_secs = 0; m_beeps = 0;
            return;
        end
        case (m_state)
            S_IDLE: if (!sp && key_ok) begin
                m_secs = shift_in(m_secs, kd); m_state = S_SET;
            end
            S_SET: begin
                if (sp) begin m_secs = 0; m_state = S_IDLE; end
                else if (st && dc && m_secs != 0) m_state = S_COOK;
                else if (key_ok) m_secs = shift_in(m_secs, kd);
            end
            S_COOK: begin
                if (sp || !dc) m_state = S_PAUSE;
                else if (t) begin
                    if (m_secs > 0) m_secs = m_secs - 1;
                    if (m_secs == 0) begin m_state = S_DONE; m_beeps = 0; end
                end
            end
            S_PAUSE: begin
                if (sp) begin m_secs = 0; m_state = S_IDLE; end
                else if (st && dc) m_state = S_COOK;
            end
            S_DONE: begin
                if (sp || st || kv) begin m_state = S_IDLE; m_beeps = 0; end
                else if (t) begin
                    m_beeps = m_beeps + 1;
                    if (m_beeps == 3) begin m_state = S_IDLE; m_beeps = 0; end
                end
            end
            default: m_state = S_IDLE;
        endcase
    endfunction

    function automatic logic [16:0] model_out();
        return pack(m_state, m_secs / 60, (m_secs % 60) / 10, m_secs % 10,
                    (m_state == S_COOK) ? 1 : 0, (m_state == S_DONE) ? 1 : 0);
    endfunction

    // ---------------- driver tasks ----------------
    // Apply one cycle of strobes (door_closed and rst_n keep their levels),
    // advance the model on the same edge, then settle before sampling.
    task automatic step(input bit t, input bit kv, input int kd, input bit st, input bit sp);
        tick_1hz  = t;
        key_valid = kv;
        key_digit = kd[3:0];
        start     = st;
        stop      = sp;
        @(posedge clk);
        model_step(rst_n, t, kv, kd, st, sp, door_closed);
        #1;
        tick_1hz = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic press(input int d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_start();
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic push_stop();
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5, 1'b1, 1'b0);
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_keys();
        press(1);
        exp_v = pack(S_SET, 0, 0, 1, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL key_first: got %h expected %h", obs, exp_v); end
        press(3); press(0);
        exp_v = pack(S_SET, 1, 3, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL keys_1_30: got %h expected %h", obs, exp_v); end
        press(7);
        exp_v = pack(S_SET, 3, 0, 7, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL key_shift_3_07: got %h expected %h", obs, exp_v); end
        press(9);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL key_ones_gt5_ignored: got %h expected %h", obs, exp_v); end
        push_stop(); press(4); press(12);
        exp_v = pack(S_SET, 0, 0, 4, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL key_non_bcd_ignored: got %h expected %h", obs, exp_v); end
        push_stop();
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL set_stop_clears: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_cook_to_done();
        press(1); press(0); press(0); push_start();
        exp_v = pack(S_COOK, 1, 0, 0, 1, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL start_cook: got %h expected %h", obs, exp_v); end
        ticks(1);
        exp_v = pack(S_COOK, 0, 5, 9, 1, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL cook_borrow_0_59: got %h expected %h", obs, exp_v); end
        ticks(58);
        exp_v = pack(S_COOK, 0, 0, 1, 1, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL cook_0_01: got %h expected %h", obs, exp_v); end
        ticks(1);
        exp_v = pack(S_DONE, 0, 0, 0, 0, 1);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL cook_to_done: got %h expected %h", obs, exp_v); end
        ticks(2);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL done_two_ticks: got %h expected %h", obs, exp_v); end
        ticks(1);
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL done_third_tick: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_pause();
        press(4); press(5); push_start();
        door_closed = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        exp_v = pack(S_PAUSE, 0, 4, 5, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL door_open_pause: got %h expected %h", obs, exp_v); end
        ticks(1); press(3);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL pause_holds: got %h expected %h", obs, exp_v); end
        door_closed = 1'b1;
        push_start();
        exp_v = pack(S_COOK, 0, 4, 5, 1, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL pause_resume: got %h expected %h", obs, exp_v); end
        push_stop();
        exp_v = pack(S_PAUSE, 0, 4, 5, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL cook_stop_pause: got %h expected %h", obs, exp_v); end
        push_stop();
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL pause_stop_clear: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_start_ignored();
        push_start();
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL idle_start_ignored: got %h expected %h", obs, exp_v); end
        press(0); push_start();
        exp_v = pack(S_SET, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL start_zero_time: got %h expected %h", obs, exp_v); end
        press(2);
        door_closed = 1'b0;
        push_start();
        exp_v = pack(S_SET, 0, 0, 2, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL start_door_open: got %h expected %h", obs, exp_v); end
        door_closed = 1'b1;
        push_stop();
    endtask

    task automatic test_back_to_back();
        press(3); press(0); push_start();
        step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        exp_v = pack(S_PAUSE, 0, 3, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL stop_beats_start: got %h expected %h", obs, exp_v); end
        push_start();
        door_closed = 1'b0;
        ticks(1);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL tick_with_door_open: got %h expected %h", obs, exp_v); end
        door_closed = 1'b1;
        push_stop();
        press(1); push_start(); ticks(1); press(5);
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL done_key_exit: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_cook();
        press(5); press(2); press(0); push_start();
        exp_v = pack(S_COOK, 5, 2, 0, 1, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL cook_5_20: got %h expected %h", obs, exp_v); end
        rst_n = 1'b0;
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_v = pack(S_IDLE, 0, 0, 0, 0, 0);
        n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL reset_mid_cook: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            door_closed = ($urandom_range(0, 19) != 0);
            rst_n       = ($urandom_range(0, 599) != 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 63) == 0);
            exp_v = model_out();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        rst_n = 1'b1;
        door_closed = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_keys();
        test_cook_to_done();
        test_pause();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_cook();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
